// File: rtl/lru_repl_ctrl.sv
// Replacement-state sequencer for one 8-way cache set: hit/miss LRU updates and the refill handshake.
// Optional perf counters are built when CACHE_REPL_PERF_EN is defined; otherwise the perf ports read 0.
module lru_repl_ctrl #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_hit_way,
    input  logic [7:0]       lru_flag,

    output logic             lru_we,
    output logic             lru_hit_sig,
    output logic [7:0]       lru_hit_way,

    output logic             refill_valid,
    input  logic             refill_ready,
    output logic [7:0]       refill_way,
    input  logic             refill_done,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [7:0]       resp_way,
    output logic             resp_err,

    output logic [CNT_W-1:0] perf_hit_cnt,
    output logic [CNT_W-1:0] perf_miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPD_HIT,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_UPD_MISS,
        S_RESP
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_t           state_q, state_d;
    logic [7:0]       way_q, way_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             hit_q, hit_d;
    logic             err_q, err_d;
    logic             req_onehot;

    // Only meaningful when req_hit_way is non-zero: exactly one bit set.
    assign req_onehot = ((req_hit_way & (req_hit_way - 8'd1)) == 8'd0);

    // NOTE: state is updated with non-blocking assignments only; the async reset
    // returns to IDLE at once, and since every output is decoded from state,
    // no pulse can escape while reset is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            way_q     <= '0;
            tmo_cnt_q <= '0;
            hit_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            way_q     <= way_d;
            tmo_cnt_q <= tmo_cnt_d;
            hit_q     <= hit_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        way_d        = way_q;
        tmo_cnt_d    = tmo_cnt_q;
        hit_d        = hit_q;
        err_d        = err_q;
        req_ready    = 1'b0;
        lru_we       = 1'b0;
        lru_hit_sig  = 1'b0;
        lru_hit_way  = '0;
        refill_valid = 1'b0;
        refill_way   = '0;
        resp_valid   = 1'b0;
        resp_hit     = 1'b0;
        resp_way     = '0;
        resp_err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    hit_d = 1'b0;
                    err_d = 1'b0;
                    if (req_hit_way == 8'd0) begin
                        way_d   = lru_flag;
                        state_d = S_REFILL_REQ;
                    end else if (req_onehot) begin
                        way_d   = req_hit_way;
                        hit_d   = 1'b1;
                        state_d = S_UPD_HIT;
                    end else begin
                        // Illegal multi-hot compare result: report it, leave LRU untouched.
                        way_d   = req_hit_way;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end

            S_UPD_HIT: begin
                lru_we      = 1'b1;
                lru_hit_sig = 1'b1;
                lru_hit_way = way_q;
                state_d     = S_RESP;
            end

            S_REFILL_REQ: begin
                refill_valid = 1'b1;
                refill_way   = way_q;
                if (refill_ready) begin
                    tmo_cnt_d = '0;
                    state_d   = S_REFILL_WAIT;
                end
            end

            S_REFILL_WAIT: begin
                // A completion arriving in the last allowed cycle still beats the timeout.
                if (refill_done) begin
                    state_d = S_UPD_MISS;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            S_UPD_MISS: begin
                lru_we      = 1'b1;
                lru_hit_way = way_q;
                state_d     = S_RESP;
            end

            S_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                resp_way   = way_q;
                resp_err   = err_q;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef CACHE_REPL_PERF_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    // Counted on the update cycle, so aborted or erroneous transactions never count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == S_UPD_HIT) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (state_q == S_UPD_MISS) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`else
    assign perf_hit_cnt  = '0;
    assign perf_miss_cnt = '0;
`endif

endmodule
